// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the write-back arbiter slice.
package wb_arb_pkg;
  localparam int NUM_REQ_DEF = 3;

  typedef logic [1:0] req_id_t;
  typedef logic [4:0] reg_idx_t;

  localparam req_id_t REQ_ALU = 2'd0;
  localparam req_id_t REQ_LSU = 2'd1;
  localparam req_id_t REQ_DBG = 2'd2;
endpackage

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin pick: search begins one past the last granted requester.
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic [N-1:0] req_i,
  input  req_id_t      last_i,
  output logic [N-1:0] gnt_o
);
  logic found;

  // Both loop indices are compile-time constants once unrolled, so no dynamic bit-select.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == (int'(last_i) + off) % N)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back port arbiter with registered register-file write outputs.
// Optional pending-write scoreboard compiled in with WB_SCOREBOARD_EN.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*5-1:0]    req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    rsv_valid,
  input  logic [4:0]              rsv_addr,
  output logic                    reg_wr,
  output logic [4:0]              waddr,
  output logic [XLEN-1:0]         wdata,
  output logic [1:0]              grant_id,
  output logic [31:0]             busy
);
  logic [NUM_REQ-1:0] gnt;
  req_id_t            last_grant_q, last_grant_d;
  logic               reg_wr_q, reg_wr_d;
  reg_idx_t           waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  req_id_t            grant_id_q, grant_id_d;
  req_id_t            sel_id;
  reg_idx_t           sel_addr;
  logic [XLEN-1:0]    sel_data;
  logic               xfer;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .gnt_o  (gnt)
  );

  assign req_ready = rst_n ? gnt : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_id   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_id   = req_id_t'(i);
        sel_addr = req_addr[i*5 +: 5];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 still consume the grant but never reach the register file.
  always_comb begin
    last_grant_d = last_grant_q;
    reg_wr_d     = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    grant_id_d   = grant_id_q;
    if (xfer) begin
      last_grant_d = sel_id;
      reg_wr_d     = (sel_addr != '0);
      waddr_d      = sel_addr;
      wdata_d      = sel_data;
      grant_id_d   = sel_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= req_id_t'(NUM_REQ - 1);
      reg_wr_q     <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      grant_id_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_wr_q     <= reg_wr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign reg_wr   = reg_wr_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign grant_id = grant_id_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Reserve is applied after the clear so a coincident set wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_wr_q) busy_d[waddr_q] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_valid, rsv_addr};
  assign busy       = '0;
`endif
endmodule
